pipeline_hazard_controller: RTL and testbench
=============================================

Name: pipeline_hazard_controller

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Drives the `freeze` input of every pipeline register (IF_to_ID, ID_to_EXE, EXE_to_MEM, MEM_to_WB), plus the PC hold, bubble-insert and flush controls.
- Handles three cases: data-cache misses in MEM (multi-cycle FSM with main-memory handshake), load-use hazards detected in ID, and taken jumps resolved in EXE.

Parameters:
- WAIT_W, 8, width of the miss-wait counter.
- MISS_TIMEOUT, 200, max cycles in MISS_WAIT before abandoning the fill; must be < 2^WAIT_W.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst_b  input  1  asynchronous active-low reset.
- cache_en_mem  input  1  MEM stage performs a cache access this cycle (EXE_to_MEM cache_en).
- cache_hit  input  1  data cache hit for the current MEM access.
- mem_ready  input  1  main memory line fill complete, 1-cycle pulse.
- load_use  input  1  ID instruction depends on a load currently in EXE.
- jump_taken  input  1  EXE stage resolved a taken jump/branch.
- freeze_pc  output  1  hold PC.
- freeze_if_id  output  1  freeze IF_to_ID.
- freeze_id_exe  output  1  freeze ID_to_EXE.
- freeze_exe_mem  output  1  freeze EXE_to_MEM.
- freeze_mem_wb  output  1  freeze MEM_to_WB.
- bubble_id_exe  output  1  load NOP (all controls 0) into ID_to_EXE.
- flush_if_id  output  1  load NOP into IF_to_ID.
- mem_req  output  1  start main-memory line fill, 1-cycle pulse.
- timeout_err  output  1  sticky flag: a fill exceeded MISS_TIMEOUT.

Behaviour:
- Reset (rst_b=0, async):
  - state=RUN, wait_cnt=0, timeout_err=0.
  - All other outputs are combinational from state and inputs, so mem_req=0 and all freeze outputs=0 while in RUN with cache_en_mem=0.
  - Reset mid-miss abandons the fill immediately; mem_req is never reissued.
- States: RUN, MISS_REQ, MISS_WAIT, MISS_DONE (2-bit encoding).
- "Freeze-all" means freeze_pc, freeze_if_id, freeze_id_exe, freeze_exe_mem and freeze_mem_wb are all 1.
- RUN, priority miss > jump > load_use:
  - Miss (cache_en_mem & ~cache_hit): freeze-all in the same cycle (Mealy), so EXE_to_MEM does not advance; next state MISS_REQ. jump_taken and load_use are ignored, since they are re-presented after the miss.
  - Else jump_taken: flush_if_id=1, bubble_id_exe=1, no freezes; stay RUN.
  - Else load_use: freeze_pc=1, freeze_if_id=1, bubble_id_exe=1; ID_to_EXE, EXE_to_MEM and MEM_to_WB advance. Exactly one bubble per cycle load_use is high.
  - Else all outputs 0.
- MISS_REQ: freeze-all, mem_req=1 for exactly this cycle, wait_cnt<=0; next MISS_WAIT.
- MISS_WAIT: freeze-all, wait_cnt increments each cycle.
  - mem_ready=1: next MISS_DONE.
  - Else wait_cnt==MISS_TIMEOUT-1: timeout_err<=1, next MISS_DONE.
  - mem_ready arriving in the timeout cycle counts as success; timeout_err stays unchanged.
- MISS_DONE: freeze-all for one cycle (cache line write); next RUN. cache_hit is expected in the following cycle.
  - If it misses again, the full sequence restarts; no special handling.
- mem_ready outside MISS_WAIT is ignored.
- timeout_err is cleared only by reset.
- bubble_id_exe and flush_if_id are never asserted outside RUN.
- Miss latency: total freeze cycles = 1 (RUN detect) + 1 (MISS_REQ) + N (MISS_WAIT) + 1 (MISS_DONE), where N = cycles until mem_ready, counting the mem_ready cycle.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- Defined: adds three outputs, each reset to 0 and saturating at all-ones:
  - stall_cycles [31:0]: increments every cycle freeze_pc=1.
  - miss_count [15:0]: increments on each RUN->MISS_REQ transition.
  - bubble_count [15:0]: increments each cycle bubble_id_exe=1.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Miss, mem_ready 3 cycles after mem_req -> freeze-all high for exactly 6 cycles, mem_req high exactly 1 cycle, then RUN with all outputs 0.
- load_use=1 for 1 cycle in RUN -> freeze_pc=freeze_if_id=bubble_id_exe=1, freeze_exe_mem=0, that cycle only.
- jump_taken=1 and load_use=1 together -> flush_if_id=1, bubble_id_exe=1, freeze_pc=0.
- Miss with jump_taken=1 in the same cycle -> miss wins: freeze-all, flush_if_id=0, state MISS_REQ next.
- MISS_TIMEOUT=4, mem_ready never asserted -> 4 MISS_WAIT cycles, then timeout_err=1 and it stays 1 after returning to RUN.
- rst_b pulsed low during MISS_WAIT -> immediately state RUN, freezes 0 (cache_en_mem=0), timeout_err=0, no further mem_req.

Source files
------------

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: data-cache miss FSM, load-use bubbles, jump flush.
// Optional HAZARD_STATS_EN adds saturating stall/miss/bubble counters.
module pipeline_hazard_controller #(
    parameter int unsigned WAIT_W       = 8,
    parameter int unsigned MISS_TIMEOUT = 200
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        cache_en_mem,
    input  logic        cache_hit,
    input  logic        mem_ready,
    input  logic        load_use,
    input  logic        jump_taken,
    output logic        freeze_pc,
    output logic        freeze_if_id,
    output logic        freeze_id_exe,
    output logic        freeze_exe_mem,
    output logic        freeze_mem_wb,
    output logic        bubble_id_exe,
    output logic        flush_if_id,
    output logic        mem_req,
    output logic        timeout_err
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [15:0] miss_count,
    output logic [15:0] bubble_count
`endif
);

    localparam logic [1:0] RUN       = 2'd0;
    localparam logic [1:0] MISS_REQ  = 2'd1;
    localparam logic [1:0] MISS_WAIT = 2'd2;
    localparam logic [1:0] MISS_DONE = 2'd3;

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MISS_TIMEOUT - 1);

    logic [1:0]        state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              timeout_err_q, timeout_err_d;
    logic              freeze_all;
    logic              lu_stall;
    logic              miss;

    assign miss = cache_en_mem & ~cache_hit;

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        timeout_err_d = timeout_err_q;
        freeze_all    = 1'b0;
        lu_stall      = 1'b0;
        bubble_id_exe = 1'b0;
        flush_if_id   = 1'b0;
        mem_req       = 1'b0;
        case (state_q)
            RUN: begin
                // Miss freezes in the detect cycle so EXE_to_MEM holds the missing access.
                if (miss) begin
                    freeze_all = 1'b1;
                    state_d    = MISS_REQ;
                end else if (jump_taken) begin
                    flush_if_id   = 1'b1;
                    bubble_id_exe = 1'b1;
                end else if (load_use) begin
                    lu_stall      = 1'b1;
                    bubble_id_exe = 1'b1;
                end
            end
            MISS_REQ: begin
                freeze_all = 1'b1;
                mem_req    = 1'b1;
                wait_cnt_d = '0;
                state_d    = MISS_WAIT;
            end
            MISS_WAIT: begin
                freeze_all = 1'b1;
                wait_cnt_d = wait_cnt_q + 1'b1;
                if (mem_ready) begin
                    state_d = MISS_DONE;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = MISS_DONE;
                end
            end
            MISS_DONE: begin
                freeze_all = 1'b1;
                state_d    = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        freeze_pc      = freeze_all | lu_stall;
        freeze_if_id   = freeze_all | lu_stall;
        freeze_id_exe  = freeze_all;
        freeze_exe_mem = freeze_all;
        freeze_mem_wb  = freeze_all;
        timeout_err    = timeout_err_q;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q       <= RUN;
            wait_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            stall_cycles <= '0;
            miss_count   <= '0;
            bubble_count <= '0;
        end else begin
            if (freeze_pc && stall_cycles != '1) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
            if (state_q == RUN && miss && miss_count != '1) begin
                miss_count <= miss_count + 1'b1;
            end
            if (bubble_id_exe && bubble_count != '1) begin
                bubble_count <= bubble_count + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller, built with MISS_TIMEOUT=4 to reach the timeout path.
module tb_pipeline_hazard_controller;

    logic clk = 1'b0;
    logic rst_b;
    logic cache_en_mem, cache_hit, mem_ready, load_use, jump_taken;
    logic freeze_pc, freeze_if_id, freeze_id_exe, freeze_exe_mem, freeze_mem_wb;
    logic bubble_id_exe, flush_if_id, mem_req, timeout_err;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles;
    logic [15:0] miss_count;
    logic [15:0] bubble_count;
`endif

    int unsigned errors = 0;
    int unsigned checks = 0;

    // Output vector: {fpc, fifid, fidexe, fexemem, fmemwb, bubble, flush, mem_req, timeout_err}
    localparam logic [8:0] Z  = 9'b00000_0000;
    localparam logic [8:0] FA = 9'b11111_0000;
    localparam logic [8:0] MR = 9'b00000_0010;
    localparam logic [8:0] TE = 9'b00000_0001;
    localparam logic [8:0] LU = 9'b11000_1000;
    localparam logic [8:0] JT = 9'b00000_1100;

    pipeline_hazard_controller #(
        .WAIT_W      (8),
        .MISS_TIMEOUT(4)
    ) dut (
        .clk           (clk),
        .rst_b         (rst_b),
        .cache_en_mem  (cache_en_mem),
        .cache_hit     (cache_hit),
        .mem_ready     (mem_ready),
        .load_use      (load_use),
        .jump_taken    (jump_taken),
        .freeze_pc     (freeze_pc),
        .freeze_if_id  (freeze_if_id),
        .freeze_id_exe (freeze_id_exe),
        .freeze_exe_mem(freeze_exe_mem),
        .freeze_mem_wb (freeze_mem_wb),
        .bubble_id_exe (bubble_id_exe),
        .flush_if_id   (flush_if_id),
        .mem_req       (mem_req),
        .timeout_err   (timeout_err)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cycles  (stall_cycles),
        .miss_count    (miss_count),
        .bubble_count  (bubble_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] outs();
        return {freeze_pc, freeze_if_id, freeze_id_exe, freeze_exe_mem, freeze_mem_wb,
                bubble_id_exe, flush_if_id, mem_req, timeout_err};
    endfunction

    task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // One clock cycle: drive {cache_en_mem, cache_hit, mem_ready, load_use, jump_taken},
    // check the combinational outputs mid-cycle, then advance past the next rising edge.
    task automatic step(input string tag, input logic [4:0] in, input logic [8:0] exp);
        {cache_en_mem, cache_hit, mem_ready, load_use, jump_taken} = in;
        #2;
        check(tag, outs(), exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_b = 1'b0;
        {cache_en_mem, cache_hit, mem_ready, load_use, jump_taken} = 5'b0;
        #1;
        check("reset", outs(), Z);
        #7;
        rst_b = 1'b1;
        @(posedge clk);
        #1;
        step("idle", 5'b00000, Z);

        // Miss, mem_ready on third wait cycle: six freeze cycles, one mem_req.
        step("m1_detect", 5'b10000, FA);
        step("m1_req",    5'b10000, FA | MR);
        step("m1_wait1",  5'b10000, FA);
        step("m1_wait2",  5'b10000, FA);
        step("m1_wait3",  5'b10100, FA);
        step("m1_done",   5'b10000, FA);
        step("m1_run",    5'b11000, Z);

        step("lu_one",    5'b00010, LU);
        step("lu_after",  5'b00000, Z);
        step("jt_lu",     5'b00011, JT);
        step("hit_jt",    5'b11001, JT);

        // Miss beats jump; mem_ready in the timeout cycle counts as success.
        step("m2_jt",     5'b10001, FA);
        step("m2_req",    5'b00001, FA | MR);
        step("m2_wait1",  5'b00000, FA);
        step("m2_wait2",  5'b00000, FA);
        step("m2_wait3",  5'b00000, FA);
        step("m2_wait4",  5'b00100, FA);
        step("m2_done",   5'b00000, FA);
        step("m2_run",    5'b00000, Z);

        // No mem_ready: four wait cycles then sticky timeout.
        step("m3_detect", 5'b10000, FA);
        step("m3_req",    5'b00000, FA | MR);
        step("m3_wait1",  5'b00000, FA);
        step("m3_wait2",  5'b00000, FA);
        step("m3_wait3",  5'b00000, FA);
        step("m3_wait4",  5'b00000, FA);
        step("m3_done",   5'b00000, FA | TE);
        step("m3_run",    5'b00000, TE);
        step("rdy_in_run", 5'b00100, TE);
        step("te_sticky", 5'b00010, LU | TE);

        // Reset during MISS_WAIT abandons the fill and clears timeout_err.
        step("m4_detect", 5'b10000, FA | TE);
        step("m4_req",    5'b00000, FA | MR | TE);
        step("m4_wait1",  5'b00000, FA | TE);
        {cache_en_mem, cache_hit, mem_ready, load_use, jump_taken} = 5'b0;
        #1;
        rst_b = 1'b0;
        #1;
        check("m4_in_reset", outs(), Z);
        #2;
        rst_b = 1'b1;
        @(posedge clk);
        #1;
        step("m4_post1",  5'b00100, Z);
        step("m4_post2",  5'b00000, Z);
        step("m4_post3",  5'b00100, Z);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
